// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: sequencer states, PC source encoding, register index.
package lc3b_types;
    typedef logic [2:0] lc3b_reg;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } pipe_state_t;

    typedef enum logic [1:0] {
        PC_SEQ     = 2'd0,
        PC_MEM     = 2'd1,
        PC_LATCHED = 2'd2
    } pc_sel_t;
endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard flag: ID reads a register that the load currently in EX will write.
module pipe_hazard_detect
    import lc3b_types::*;
(
    input  logic    ex_is_load,
    input  lc3b_reg ex_dr,
    input  lc3b_reg id_sr1,
    input  lc3b_reg id_sr2,
    input  logic    id_use_sr1,
    input  logic    id_use_sr2,
    output logic    load_use
);
    assign load_use = ex_is_load &
                      ((id_use_sr1 & (id_sr1 == ex_dr)) |
                       (id_use_sr2 & (id_sr2 == ex_dr)));
endmodule

// File: rtl/pipe_ctrl.sv
// LC-3b five-stage pipeline sequencer: stage loads, flush selects and PC source.
// Optional PIPE_CTRL_PERF_EN adds stall/bubble/flush cycle counters and perf_clr.
module pipe_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        ex_is_load,
    input  lc3b_reg     ex_dr,
    input  lc3b_reg     id_sr1,
    input  lc3b_reg     id_sr2,
    input  logic        id_use_sr1,
    input  logic        id_use_sr2,
    input  logic        mem_br_taken,
`ifdef PIPE_CTRL_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_dstall,
    output logic [31:0] perf_istall,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_flush,
`endif
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        load_br_target,
    output logic [1:0]  pc_sel
);
    pipe_state_t state_q, state_d;
    pc_sel_t     pc_sel_d;
    logic        load_use;
    logic        d_stall;
    logic        i_stall;

    pipe_hazard_detect u_hazard (
        .ex_is_load (ex_is_load),
        .ex_dr      (ex_dr),
        .id_sr1     (id_sr1),
        .id_sr2     (id_sr2),
        .id_use_sr1 (id_use_sr1),
        .id_use_sr2 (id_use_sr2),
        .load_use   (load_use)
    );

    assign d_stall = dmem_req & ~dmem_resp;
    assign i_stall = imem_read & ~imem_resp;
    assign pc_sel  = pc_sel_d;

`ifdef PIPE_CTRL_PERF_EN
    logic hit_dstall, hit_istall, hit_bubble, hit_flush;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_pc        = 1'b0;
        load_if_id     = 1'b0;
        load_id_ex     = 1'b0;
        load_ex_mem    = 1'b0;
        load_mem_wb    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        load_br_target = 1'b0;
        pc_sel_d       = PC_SEQ;
`ifdef PIPE_CTRL_PERF_EN
        hit_dstall = 1'b0;
        hit_istall = 1'b0;
        hit_bubble = 1'b0;
        hit_flush  = 1'b0;
`endif
        if (!rst_n) begin
            state_d = RUN;
        end else if (state_q == BR_WAIT) begin
            // Wrong-path fetch still in flight: keep draining bubbles until it returns.
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
            hit_flush = 1'b1;
`endif
            if (imem_resp) begin
                load_pc  = 1'b1;
                pc_sel_d = PC_LATCHED;
                state_d  = RUN;
            end
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (d_stall) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                load_id_ex  = 1'b0;
                load_ex_mem = 1'b0;
                load_mem_wb = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
                hit_dstall = 1'b1;
`endif
            end else if (mem_br_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
                hit_flush = 1'b1;
`endif
                if (i_stall) begin
                    load_pc        = 1'b0;
                    load_br_target = 1'b1;
                    state_d        = BR_WAIT;
                end else begin
                    pc_sel_d = PC_MEM;
                end
            end else if (load_use) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                flush_id_ex = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
                hit_bubble = 1'b1;
`endif
            end else if (i_stall) begin
                load_pc     = 1'b0;
                flush_if_id = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
                hit_istall = 1'b1;
`endif
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] dstall_q, istall_q, bubble_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstall_q <= '0;
            istall_q <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (perf_clr) begin
            dstall_q <= '0;
            istall_q <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            dstall_q <= dstall_q + {31'd0, hit_dstall};
            istall_q <= istall_q + {31'd0, hit_istall};
            bubble_q <= bubble_q + {31'd0, hit_bubble};
            flush_q  <= flush_q  + {31'd0, hit_flush};
        end
    end

    assign perf_dstall = dstall_q;
    assign perf_istall = istall_q;
    assign perf_bubble = bubble_q;
    assign perf_flush  = flush_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of single-cycle RUN vectors plus multi-cycle redirect/reset sequences.
module tb_pipe_ctrl;
    import lc3b_types::*;

    typedef struct packed {
        logic    imem_read;
        logic    imem_resp;
        logic    dmem_req;
        logic    dmem_resp;
        logic    ex_is_load;
        lc3b_reg ex_dr;
        lc3b_reg id_sr1;
        lc3b_reg id_sr2;
        logic    use1;
        logic    use2;
        logic    br;
    } vin_t;

    // {load_pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, load_br_target, pc_sel}
    typedef logic [10:0] vout_t;

    typedef struct {
        vin_t  in;
        vout_t exp;
        string name;
    } vec_t;

    localparam vout_t O_IDLE  = 11'b11111_000_0_00;
    localparam vout_t O_DSTL  = 11'b00000_000_0_00;
    localparam vout_t O_RIMM  = 11'b11111_111_0_01;
    localparam vout_t O_RWAIT = 11'b01111_111_1_00;
    localparam vout_t O_LU    = 11'b00111_010_0_00;
    localparam vout_t O_ISTL  = 11'b01111_100_0_00;
    localparam vout_t O_BWH   = 11'b01111_111_0_00;
    localparam vout_t O_BWR   = 11'b11111_111_0_10;
    localparam vout_t O_ZERO  = 11'b00000_000_0_00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    vin_t in_r = '0;
    logic lpc, lifid, lidex, lexmem, lmemwb, fifid, fidex, fexmem, lbt;
    logic [1:0] psel;
    vout_t act;

    int n_chk = 0;
    int n_fail = 0;

    vout_t exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
    logic perf_clr = 1'b0;
    logic [31:0] p_dstall, p_istall, p_bubble, p_flush;
`endif

    pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_read      (in_r.imem_read),
        .imem_resp      (in_r.imem_resp),
        .dmem_req       (in_r.dmem_req),
        .dmem_resp      (in_r.dmem_resp),
        .ex_is_load     (in_r.ex_is_load),
        .ex_dr          (in_r.ex_dr),
        .id_sr1         (in_r.id_sr1),
        .id_sr2         (in_r.id_sr2),
        .id_use_sr1     (in_r.use1),
        .id_use_sr2     (in_r.use2),
        .mem_br_taken   (in_r.br),
`ifdef PIPE_CTRL_PERF_EN
        .perf_clr       (perf_clr),
        .perf_dstall    (p_dstall),
        .perf_istall    (p_istall),
        .perf_bubble    (p_bubble),
        .perf_flush     (p_flush),
`endif
        .load_pc        (lpc),
        .load_if_id     (lifid),
        .load_id_ex     (lidex),
        .load_ex_mem    (lexmem),
        .load_mem_wb    (lmemwb),
        .flush_if_id    (fifid),
        .flush_id_ex    (fidex),
        .flush_ex_mem   (fexmem),
        .load_br_target (lbt),
        .pc_sel         (psel)
    );

    assign act = {lpc, lifid, lidex, lexmem, lmemwb, fifid, fidex, fexmem, lbt, psel};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, compare at the negedge, end just past the posedge.
    task automatic step(input vin_t v, input vout_t e, input string name);
        vout_t ex;
        string nm;
        in_r = v;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk);
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {21'd0, act}, {21'd0, ex});
        @(posedge clk);
        #1;
    endtask

    function automatic vin_t mk(input logic ir, input logic irs, input logic dq, input logic drs,
                                input logic ld, input int dr, input int s1, input int s2,
                                input logic u1, input logic u2, input logic br);
        vin_t v;
        v.imem_read = ir; v.imem_resp = irs; v.dmem_req = dq; v.dmem_resp = drs;
        v.ex_is_load = ld; v.ex_dr = dr[2:0]; v.id_sr1 = s1[2:0]; v.id_sr2 = s2[2:0];
        v.use1 = u1; v.use2 = u2; v.br = br;
        return v;
    endfunction

    vec_t tbl[16];
    vin_t idle, lu;

    initial begin
        idle = '0;
        lu   = mk(0,0,0,0, 1,2,2,5, 1,0, 0);

        tbl[0]  = '{idle,                            O_IDLE, "idle"};
        tbl[1]  = '{mk(1,1,0,0, 0,0,0,0, 0,0, 0),    O_IDLE, "fetch_hit"};
        tbl[2]  = '{mk(1,0,0,0, 0,0,0,0, 0,0, 0),    O_ISTL, "istall"};
        tbl[3]  = '{lu,                              O_LU,   "lu_sr1"};
        tbl[4]  = '{mk(0,0,0,0, 1,6,1,6, 0,1, 0),    O_LU,   "lu_sr2"};
        tbl[5]  = '{mk(0,0,0,0, 1,2,2,2, 0,0, 0),    O_IDLE, "lu_unused_src"};
        tbl[6]  = '{mk(0,0,0,0, 0,2,2,2, 1,1, 0),    O_IDLE, "not_load"};
        tbl[7]  = '{mk(0,0,0,0, 1,2,3,4, 1,1, 0),    O_IDLE, "no_match"};
        tbl[8]  = '{mk(0,0,1,0, 0,0,0,0, 0,0, 0),    O_DSTL, "dstall"};
        tbl[9]  = '{mk(0,0,1,1, 0,0,0,0, 0,0, 0),    O_IDLE, "dmem_done"};
        tbl[10] = '{mk(1,0,1,0, 0,0,0,0, 0,0, 1),    O_DSTL, "dstall_over_br"};
        tbl[11] = '{mk(0,0,0,0, 0,0,0,0, 0,0, 1),    O_RIMM, "redir_imm"};
        tbl[12] = '{mk(1,1,0,0, 0,0,0,0, 0,0, 1),    O_RIMM, "redir_with_resp"};
        tbl[13] = '{mk(0,0,0,0, 1,2,2,5, 1,0, 1),    O_RIMM, "redir_over_lu"};
        tbl[14] = '{mk(1,0,0,0, 1,7,0,7, 0,1, 0),    O_LU,   "lu_over_istall"};
        tbl[15] = '{mk(0,0,0,1, 0,0,0,0, 0,0, 0),    O_IDLE, "dresp_no_req"};

        // Reset: outputs forced low even with active inputs.
        in_r = mk(1,0,0,0, 0,0,0,0, 0,0, 1);
        #2;
        check("reset_outputs", {21'd0, act}, 32'd0);
        @(posedge clk); #1;
        check("reset_outputs_clk", {21'd0, act}, 32'd0);
        in_r = idle;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

        // Load-use: exactly one bubble once the load leaves EX.
        step(lu, O_LU, "lu_bubble");
        step(mk(0,0,0,0, 0,2,2,5, 1,0, 0), O_IDLE, "lu_cleared");

        // D-stall dominates a concurrent load-use for 4 cycles.
        for (int i = 0; i < 4; i++) step(mk(0,0,1,0, 1,2,2,5, 1,0, 0), O_DSTL, "dstall_lu");
        step(mk(0,0,1,1, 1,2,2,5, 1,0, 0), O_LU, "lu_after_dstall");
        step(idle, O_IDLE, "after_dstall_lu");

        // Immediate redirect keeps the sequencer in RUN.
        step(mk(0,0,0,0, 0,0,0,0, 0,0, 1), O_RIMM, "redir_imm_seq");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_ISTL, "run_after_redir");

        // Redirect during outstanding fetch, response 3 cycles later.
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 1), O_RWAIT, "brw_enter");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 1), O_BWH,   "brw_hold_br_ignored");
        step(mk(1,0,1,0, 1,3,3,3, 1,1, 0), O_BWH,   "brw_hold_stalls_ignored");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_BWH,   "brw_hold3");
        step(mk(1,1,0,0, 0,0,0,0, 0,0, 0), O_BWR,   "brw_resp");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_ISTL,  "brw_back_to_run");

        // Reset asserted in the second BR_WAIT cycle.
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 1), O_RWAIT, "rst_brw_enter");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_BWH,   "rst_brw_hold1");
        in_r = mk(1,0,0,0, 0,0,0,0, 0,0, 0);
        #2;
        check("rst_brw_pre", {21'd0, act}, {21'd0, O_BWH});
        rst_n = 1'b0;
        #1;
        check("rst_brw_async_zero", {21'd0, act}, {21'd0, O_ZERO});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(mk(1,1,0,0, 0,0,0,0, 0,0, 0), O_IDLE, "rst_brw_run_seq");
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_ISTL, "rst_brw_run_istall");

`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 1'b1;
        step(idle, O_IDLE, "perf_preclr");
        perf_clr = 1'b0;
        for (int i = 0; i < 5; i++) step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_ISTL, "perf_istall_cyc");
        check("perf_istall_5", p_istall, 32'd5);
        check("perf_dstall_0", p_dstall, 32'd0);
        perf_clr = 1'b1;
        step(mk(1,0,0,0, 0,0,0,0, 0,0, 0), O_ISTL, "perf_clr_cyc");
        perf_clr = 1'b0;
        check("perf_istall_clr", p_istall, 32'd0);
`endif

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the LC-3b five-stage core (IF, ID, EX, MEM, WB). It owns the `load` and flush/bubble select of every stage control-word register, the PC load, and the PC source select. It resolves cache stalls, load-use hazards and taken-branch redirects, including a redirect that arrives while an I-cache fetch is still outstanding. It sits beside the datapath, between the stage registers and the two cache ports.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, posedge.
- `rst_n` in 1: reset, asynchronous assert, active low.
- `imem_read` in 1: IF has an I-cache read outstanding.
- `imem_resp` in 1: I-cache read completes this cycle.
- `dmem_req` in 1: MEM-stage read or write outstanding.
- `dmem_resp` in 1: D-cache access completes this cycle.
- `ex_is_load` in 1: EX holds LDB/LDR/LDI.
- `ex_dr` in 3: EX destination register.
- `id_sr1`, `id_sr2` in 3 each: ID source registers.
- `id_use_sr1`, `id_use_sr2` in 1 each: ID actually reads that source.
- `mem_br_taken` in 1: MEM resolves a taken branch, JMP, JSR or TRAP.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: stage register enables.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: select the NOP control word into that register on its load.
- `load_br_target` out 1: latch the MEM branch target into the redirect register.
- `pc_sel` out 2: PC source. `PC_SEQ`=0 selects PC+2, `PC_MEM`=1 selects the MEM target, `PC_LATCHED`=2 selects the redirect register.

## Operation
- States: `RUN` and `BR_WAIT`. All outputs are combinational from the state and the inputs.
- While `rst_n`=0, every output is 0, `pc_sel`=`PC_SEQ`, and the state is `RUN`.
- Default in `RUN`: all five loads = 1, all flushes = 0, `pc_sel`=`PC_SEQ`.
- Conditions are evaluated in priority order, highest first. Only the first true condition applies.
  1. **D-stall**: `dmem_req & ~dmem_resp`. All loads = 0 and all flushes = 0.
  2. **Redirect**: `mem_br_taken`.
     - If `imem_read & ~imem_resp`:
       - `load_pc`=0, `load_br_target`=1.
       - IF/ID, ID/EX and EX/MEM load with flush = 1; `load_mem_wb`=1.
       - Next state is `BR_WAIT`.
     - Otherwise: `load_pc`=1, `pc_sel`=`PC_MEM`, all three flushes = 1, all loads = 1.
  3. **Load-use**: `ex_is_load & ((id_use_sr1 & id_sr1==ex_dr) | (id_use_sr2 & id_sr2==ex_dr))`.
     - `load_pc`=0, `load_if_id`=0.
     - `load_id_ex`=1 with `flush_id_ex`=1, which injects one bubble.
  4. **I-stall**: `imem_read & ~imem_resp`.
     - `load_pc`=0.
     - `load_if_id`=1 with `flush_if_id`=1, which injects a bubble.
     - Downstream stages advance.
- In `BR_WAIT`:
  - `mem_br_taken`, load-use and `dmem_req` are ignored; MEM holds a bubble.
  - IF/ID, ID/EX and EX/MEM keep loading with flush = 1; `load_mem_wb`=1.
  - `load_pc`=0 until `imem_resp`=1.
  - On `imem_resp`=1: `load_pc`=1, `pc_sel`=`PC_LATCHED`, `flush_if_id`=1 to discard the wrong-path word. Next state is `RUN`.
- An outstanding I-cache read is never abandoned; the PC is not changed while `imem_read & ~imem_resp`.

## Timing
- Stall, bubble and flush decisions take effect in the same cycle as the input that causes them (0-cycle combinational path). Registers update on the next posedge.
- Load-use costs exactly 1 bubble cycle: the condition clears once the load reaches MEM.
- Redirect with no fetch outstanding costs 3 flushed slots and no extra cycle. The new PC is loaded at the posedge following `mem_br_taken`.
- Redirect during an outstanding fetch stays in `BR_WAIT` for N cycles, where N is the number of cycles until `imem_resp`. The redirect register is written exactly once, on entry.
- If `mem_br_taken` and `imem_resp` are both 1 in `RUN`, the immediate redirect applies (`PC_MEM`) and no `BR_WAIT` is entered.
- Reset asserted mid-`BR_WAIT` returns to `RUN` immediately. The latched target is discarded.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds four 32-bit wrapping counters: `perf_dstall`, `perf_istall`, `perf_bubble`, `perf_flush`.
  - Each counts the cycles in which its condition is the applied one. `BR_WAIT` cycles count as flush.
  - Adds input `perf_clr`, which synchronously zeroes all counters and takes priority over incrementing.
  - Counters reset to 0 asynchronously.
- Macro undefined: counters and the `perf_*` ports do not exist; control behaviour is identical.

## Structure
- `lc3b_types` holds the `pipe_state_t` enum (`RUN`, `BR_WAIT`), the `pc_sel_t` enum, and `lc3b_reg` (3 bits).
- Sub-module `pipe_hazard_detect` is purely combinational and produces the load-use flag from the EX/ID fields.

## Test plan
- EX=LDR with `ex_dr`=R2, ID=ADD with `id_sr1`=R2 and `id_use_sr1`=1 -> one cycle with `load_pc`=0, `load_if_id`=0, `flush_id_ex`=1; next cycle all loads = 1.
- `dmem_req`=1 with `dmem_resp` low for 4 cycles while a load-use is also present -> 4 cycles with all loads = 0, then the load-use bubble.
- `mem_br_taken`=1 with `imem_read`=0 -> `load_pc`=1, `pc_sel`=1, three flushes = 1; state stays `RUN`.
- `mem_br_taken`=1 with a fetch outstanding and `imem_resp` arriving 3 cycles later -> `load_br_target` pulses once; 3 cycles with `load_pc`=0; then `load_pc`=1, `pc_sel`=2, `flush_if_id`=1; state returns to `RUN`.
- `rst_n` dropped in the second `BR_WAIT` cycle -> outputs go to 0 immediately; after release the state is `RUN` and `pc_sel`=0.
- With `PIPE_CTRL_PERF_EN`: 5 I-stall cycles then a `perf_clr` pulse -> `perf_istall`=5, then 0 on the next cycle.
